// File: rtl/dff_pkg.sv
// Shared register-level constants and the enable/disable
// strobes used to tie off clear and stall on plain registers.
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package dff_pkg;

  localparam logic ENABLE_C  = `ENABLE;
  localparam logic DISABLE_C = `DISABLE;

endpackage

// File: rtl/dff.sv
// Leaf state primitive: synchronous reset/clear/stall register.
// rst_n keeps its legacy name but is active-high.
module dff
  import dff_pkg::*;
#(
  parameter int             WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset beats clear beats stall beats load.
  always_ff @(posedge clk) begin
    if (rst_n == ENABLE_C)
      q <= RESET_VALUE;
    else if (clear == ENABLE_C)
      q <= RESET_VALUE;
    else if (stall == DISABLE_C)
      q <= d;
  end

endmodule

// File: tb/tb_dff.sv
// Directed scoreboard bench for dff at WIDTH=2 and WIDTH=8.
`timescale 1ns/1ps
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

module tb_dff;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, clr2, stl2;
  logic [1:0] d2, q2;
  logic       rst8, clr8, stl8;
  logic [7:0] d8, q8;

  dff #(2, 2'b00) u2 (
    .clk(clk), .rst_n(rst2), .clear(clr2),
    .stall(stl2), .d(d2), .q(q2)
  );

  dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .clk(clk), .rst_n(rst8), .clear(clr8),
    .stall(stl8), .d(d8), .q(q8)
  );

  logic [7:0] exp_q[$];
  logic       sel_q[$];
  string      tag_q[$];

  int vectors = 0;
  int errs    = 0;

  task automatic check_all();
    logic [7:0] e, o;
    logic       s;
    string      t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      o = s ? q8 : {6'b0, q2};
      vectors++;
      assert (o === e) else begin
        errs++;
        $error("FAIL %s: got %h want %h", t, o, e);
      end
    end
  endtask

  task automatic step2(input logic r, input logic c,
                       input logic s, input logic [1:0] d,
                       input logic [1:0] e, input string t);
    @(negedge clk);
    rst2 = r; clr2 = c; stl2 = s; d2 = d;
    exp_q.push_back({6'b0, e});
    sel_q.push_back(1'b0);
    tag_q.push_back(t);
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic step8(input logic r, input logic c,
                       input logic s, input logic [7:0] d,
                       input logic [7:0] e, input string t);
    @(negedge clk);
    rst8 = r; clr8 = c; stl8 = s; d8 = d;
    exp_q.push_back(e);
    sel_q.push_back(1'b1);
    tag_q.push_back(t);
    @(posedge clk);
    #1 check_all();
  endtask

  initial begin
    rst2 = 1'b1; clr2 = 1'b0; stl2 = 1'b0; d2 = 2'b11;
    rst8 = 1'b1; clr8 = 1'b0; stl8 = 1'b0; d8 = 8'hFF;

    step2(1, 0, 0, 2'b11, 2'b00, "w2_rst1");
    step2(1, 0, 0, 2'b11, 2'b00, "w2_rst2");
    step2(0, 0, 0, 2'b01, 2'b01, "w2_load01");
    step2(0, 0, 0, 2'b10, 2'b10, "w2_load10");
    step2(0, `DISABLE, `DISABLE, 2'b00, 2'b00, "w2_seq00");
    step2(0, `DISABLE, `DISABLE, 2'b01, 2'b01, "w2_seq01");
    step2(0, `DISABLE, `DISABLE, 2'b10, 2'b10, "w2_seq10");
    step2(0, `DISABLE, `DISABLE, 2'b00, 2'b00, "w2_seq00b");
    step2(0, 0, 0, 2'b11, 2'b11, "w2_all1");
    step2(0, 1, 0, 2'b01, 2'b00, "w2_clear");

    step8(1, 0, 0, 8'h77, 8'hA5, "w8_rst");
    step8(0, 0, 0, 8'h3C, 8'h3C, "w8_load");
    step8(0, 1, 0, 8'h3C, 8'hA5, "w8_clear");
    step8(0, 0, 0, 8'h3C, 8'h3C, "w8_reload");
    step8(0, 0, 1, 8'h01, 8'h3C, "w8_stall1");
    step8(0, 0, 1, 8'h02, 8'h3C, "w8_stall2");
    step8(0, 0, 1, 8'h03, 8'h3C, "w8_stall3");
    step8(0, 0, 0, 8'h03, 8'h03, "w8_unstall");
    step8(0, 0, 0, 8'h3C, 8'h3C, "w8_pre_cs");
    step8(0, 1, 1, 8'hFF, 8'hA5, "w8_clr_stall");
    step8(0, 0, 0, 8'h3C, 8'h3C, "w8_pre_pulse");

    // Reset pulse that never spans an edge must be ignored.
    @(negedge clk);
    stl8 = 1'b1; d8 = 8'h99; rst8 = 1'b1;
    #1;
    vectors++;
    assert (q8 === 8'h3C) else begin
      errs++;
      $error("FAIL w8_rst_async: got %h want %h", q8, 8'h3C);
    end
    #1 rst8 = 1'b0;
    exp_q.push_back(8'h3C);
    sel_q.push_back(1'b1);
    tag_q.push_back("w8_rst_pulse");
    @(posedge clk);
    #1 check_all();

    step8(1, 0, 0, 8'h77, 8'hA5, "w8_rst_edge");
    step8(0, 0, 0, 8'h5A, 8'h5A, "w8_load5A");
    step8(1, 1, 1, 8'hFF, 8'hA5, "w8_rst_all");
    step8(0, 1, 0, 8'h11, 8'hA5, "w8_post_clr");
    step8(0, 0, 1, 8'h22, 8'hA5, "w8_post_stl");
    step8(0, 0, 0, 8'h33, 8'h33, "w8_first_ld");

    // Input change between edges must not reach q.
    @(negedge clk);
    stl8 = 1'b0; d8 = 8'hC3;
    #1;
    vectors++;
    assert (q8 === 8'h33) else begin
      errs++;
      $error("FAIL w8_no_bypass: got %h want %h", q8, 8'h33);
    end
    exp_q.push_back(8'hC3);
    sel_q.push_back(1'b1);
    tag_q.push_back("w8_latency");
    @(posedge clk);
    #1 check_all();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
